// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run-length detector: state encoding,
// default parameter values and a saturating increment.
package run_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DETECT = 2'd2
    } run_state_e;

    localparam int   DEF_CNT_W  = 4;
    localparam int   DEF_HIT_W  = 8;
    localparam logic DEF_MATCH  = 1'b1;
    localparam int   DEF_RETRIG = 0;

    // Increment v by one, holding at max once reached.
    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
        return (v >= max) ? max : v + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; a clear that coincides
// with an increment leaves the count at 1 so that event is not lost.
module sat_counter
    import run_det_pkg::*;
#(
    parameter int W = DEF_HIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam int unsigned Q_MAX = (1 << W) - 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc) begin
            q <= W'(sat_inc(32'(q), Q_MAX));
        end
    end

endmodule

// File: rtl/run_detector.sv
// Counts consecutive samples of x equal to MATCH and flags runs of at least
// len samples, with an optional non-overlapping (retrigger) mode.
module run_detector
    import run_det_pkg::*;
#(
    parameter int   CNT_W  = DEF_CNT_W,
    parameter int   HIT_W  = DEF_HIT_W,
    parameter logic MATCH  = DEF_MATCH,
    parameter int   RETRIG = DEF_RETRIG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic [CNT_W-1:0] len,
    input  logic             clr_hits,
    output logic             y,
    output logic             y_early,
    output logic             hit,
    output logic [CNT_W-1:0] run,
    output logic [HIT_W-1:0] hits,
    output run_state_e       dbg_state
);

    localparam int unsigned RUN_MAX = (1 << CNT_W) - 1;

    // en is a plain sample qualifier, not a handshake: a sample is consumed on
    // every rising edge where en=1, and nothing in the block ever stalls it.

    run_state_e       state;
    run_state_e       state_n;
    logic [CNT_W-1:0] run_n;
    logic             det_n;
    logic             restart;
    logic             hit_n;

    always_comb begin
        run_n   = run;
        restart = 1'b0;
        if (en) begin
            if (x != MATCH) begin
                run_n = '0;
            end else if ((RETRIG != 0) && (state == DETECT)) begin
                run_n   = CNT_W'(1);
                restart = 1'b1;
            end else begin
                run_n = CNT_W'(sat_inc(32'(run), RUN_MAX));
            end
        end

        det_n = (len != '0) && (run_n >= len);
        // A restart only re-detects when len=1; otherwise only DETECT entry pulses.
        hit_n = en && det_n && ((state != DETECT) || restart);

        if (run_n == '0) begin
            state_n = IDLE;
        end else if (det_n) begin
            state_n = DETECT;
        end else begin
            state_n = COUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            run   <= '0;
            y     <= 1'b0;
            hit   <= 1'b0;
        end else if (en) begin
            state <= state_n;
            run   <= run_n;
            y     <= det_n;
            hit   <= hit_n;
        end else begin
            hit <= 1'b0;
        end
    end

    assign y_early   = en && (x == MATCH) && det_n;
    assign dbg_state = state;

    sat_counter #(
        .W(HIT_W)
    ) u_hits (
        .clk(clk),
        .rst(rst),
        .clr(clr_hits && en),
        .inc(hit_n),
        .q  (hits)
    );

endmodule
